// File: rtl/de1_to_arduino_tx.sv
// Clock/data/latch serial transmitter from the DE1 to an Arduino shift-register-style receiver.
// Define DE1_TX_PARITY_EN to append an even-parity bit after the LSB of every frame.
module de1_to_arduino_tx #(
    parameter int DATA_W = 8,
    parameter int DIV    = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              send,
    output logic              busy,
    output logic              done,
    output logic              gpio_sclk,
    output logic              gpio_data,
    output logic              gpio_latch
);

`ifdef DE1_TX_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BIT_LO,
        BIT_HI,
        LATCH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] shreg_next;
    logic [FRAME_W-1:0] frame_word;
    logic               phase_end;

    // Parity is taken from the word being captured, so later data_in changes cannot alter it.
`ifdef DE1_TX_PARITY_EN
    assign frame_word = {data_in, ^data_in};
`else
    assign frame_word = data_in;
`endif

    assign shreg_next = shreg << 1;
    assign phase_end  = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gpio_sclk  <= 1'b0;
            gpio_data  <= 1'b0;
            gpio_latch <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        shreg     <= frame_word;
                        gpio_data <= frame_word[FRAME_W-1];
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= BIT_LO;
                    end
                end
                BIT_LO: begin
                    if (phase_end) begin
                        div_cnt   <= '0;
                        gpio_sclk <= 1'b1;
                        state     <= BIT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                BIT_HI: begin
                    if (phase_end) begin
                        div_cnt   <= '0;
                        gpio_sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            gpio_data  <= 1'b0;
                            gpio_latch <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            // Next bit goes out with the falling clock so it is settled by the next rise.
                            shreg     <= shreg_next;
                            gpio_data <= shreg_next[FRAME_W-1];
                            bit_cnt   <= bit_cnt + 1'b1;
                            state     <= BIT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        div_cnt    <= '0;
                        gpio_latch <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_de1_to_arduino_tx.sv
// Self-checking bench for de1_to_arduino_tx: an Arduino-style receiver model decodes the GPIO lines.
// Honours DE1_TX_PARITY_EN in the expected frame contents and lengths.
module tb_de1_to_arduino_tx;

    localparam int DATA_W = 8;
`ifdef DE1_TX_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;
    localparam int LEN_A = (2 * NB + 1) * DIV_A;
    localparam int LEN_B = (2 * NB + 1) * DIV_B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic       send_a = 1'b0;
    logic       send_b = 1'b0;
    logic       busy_a, done_a, sclk_a, sdat_a, latch_a;
    logic       busy_b, done_b, sclk_b, sdat_b, latch_b;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] word;
        int         ignore_at;
        logic [7:0] ignore_word;
        int         exp_rx;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    de1_to_arduino_tx #(.DATA_W(DATA_W), .DIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .send(send_a),
        .busy(busy_a), .done(done_a), .gpio_sclk(sclk_a), .gpio_data(sdat_a), .gpio_latch(latch_a)
    );

    de1_to_arduino_tx #(.DATA_W(DATA_W), .DIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .send(send_b),
        .busy(busy_b), .done(done_b), .gpio_sclk(sclk_b), .gpio_data(sdat_b), .gpio_latch(latch_b)
    );

    // The bit sequence the Arduino should have shifted in by the time it sees the latch.
    function automatic int frameBits(input logic [7:0] w);
`ifdef DE1_TX_PARITY_EN
        return (int'(w) << 1) | int'(^w);
`else
        return int'(w);
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One frame on the DIV=4 instance, with an optional ignored send while busy.
    task automatic applyStimulus(input string tag, input logic [7:0] word, input int ignore_at,
                                 input logic [7:0] ignore_word, input int exp_rx);
        int   busy_n = 0, done_n = 0, done_at = -1;
        int   latch_n = 0, latch_first = -1, latch_bad = 0;
        int   rise_n = 0, rise_bad = 0, glitch = 0, first_ok = 0;
        int   rx = 0;
        logic prev_sclk = 1'b0, prev_data = 1'b0;
        @(posedge clk);
        #1;
        data_a = word;
        send_a = 1'b1;
        for (int c = 1; c <= LEN_A + 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                send_a = 1'b0;
                data_a = 8'($urandom);
            end
            if (c == ignore_at) begin
                send_a = 1'b1;
                data_a = ignore_word;
            end
            if (c == ignore_at + 1) send_a = 1'b0;
            @(negedge clk);
            if (c == 1) first_ok = int'(busy_a === 1'b1 && sdat_a === word[7]);
            if (busy_a) busy_n++;
            if (done_a) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (sclk_a && !prev_sclk) begin
                if (c != DIV_A + 1 + rise_n * 2 * DIV_A) rise_bad++;
                rx = (rx << 1) | int'(sdat_a);
                rise_n++;
            end
            if (sclk_a && prev_sclk && sdat_a != prev_data) glitch++;
            if (latch_a) begin
                latch_n++;
                if (latch_first < 0) latch_first = c;
                if (sclk_a || sdat_a) latch_bad++;
            end
            prev_sclk = sclk_a;
            prev_data = sdat_a;
        end
        checkOutput({tag, "_first_cycle"}, first_ok, 1);
        checkOutput({tag, "_busy_len"}, busy_n, LEN_A);
        checkOutput({tag, "_done_count"}, done_n, 1);
        checkOutput({tag, "_done_cycle"}, done_at, LEN_A + 1);
        checkOutput({tag, "_rise_count"}, rise_n, NB);
        checkOutput({tag, "_rise_timing"}, rise_bad, 0);
        checkOutput({tag, "_data_stable"}, glitch, 0);
        checkOutput({tag, "_latch_start"}, latch_first, 2 * NB * DIV_A + 1);
        checkOutput({tag, "_latch_len"}, latch_n, DIV_A);
        checkOutput({tag, "_latch_lines"}, latch_bad, 0);
        checkOutput({tag, "_rx_word"}, rx, exp_rx);
    endtask

    initial begin
        int   idle_bad = 0;
        int   runs[$];
        int   exp_q[$];
        int   got_q[$];
        int   run_len = 0, gap_len = 0, gaps_bad = 0, done_bad = 0, run_bad = 0;
        int   rx_b = 0;
        logic seen_run = 1'b0, prev_sclk_b = 1'b0, prev_latch_b = 1'b0;
        logic [7:0] w;

        vecs[0] = '{8'hA5, 10, 8'hFF, frameBits(8'hA5)};
        vecs[1] = '{8'h3C, 0,  8'h00, frameBits(8'h3C)};
        vecs[2] = '{8'h07, 20, 8'h00, frameBits(8'h07)};
        vecs[3] = '{8'h03, 40, 8'h55, frameBits(8'h03)};
        vecs[4] = '{8'h00, 5,  8'hFF, frameBits(8'h00)};
        vecs[5] = '{8'hFF, 60, 8'h00, frameBits(8'hFF)};
        vecs[6] = '{8'h80, 2,  8'h7F, frameBits(8'h80)};
        vecs[7] = '{8'h01, 33, 8'hFE, frameBits(8'h01)};

        $display("[TB] start, frame bits %0d", NB);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs_a", int'({busy_a, done_a, sclk_a, sdat_a, latch_a}), 0);
        checkOutput("reset_outputs_b", int'({busy_b, done_b, sclk_b, sdat_b, latch_b}), 0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if ({busy_a, done_a, sclk_a, sdat_a, latch_a} != 5'b0) idle_bad++;
        end
        checkOutput("idle_quiet", idle_bad, 0);

        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].word, vecs[i].ignore_at, vecs[i].ignore_word, vecs[i].exp_rx);

        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            applyStimulus($sformatf("rand%0d", i), w, $urandom_range(LEN_A - 4, 2), 8'($urandom), frameBits(w));
        end

        // Mid-frame asynchronous reset, then a clean frame.
        @(posedge clk);
        #1;
        data_a = 8'h55;
        send_a = 1'b1;
        @(posedge clk);
        #1;
        send_a = 1'b0;
        repeat (28) @(posedge clk);
        #2;
        checkOutput("busy_before_rst", int'(busy_a), 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_outputs", int'({busy_a, done_a, sclk_a, sdat_a, latch_a}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("held_rst_outputs", int'({busy_a, done_a, sclk_a, sdat_a, latch_a}), 0);
        rst = 1'b0;
        applyStimulus("after_rst", 8'h3C, 0, 8'h00, frameBits(8'h3C));

        // Back-to-back frames with send held high on the DIV=1 instance.
        @(posedge clk);
        #1;
        data_b = 8'($urandom);
        exp_q.push_back(frameBits(data_b));
        send_b = 1'b1;
        for (int c = 1; c <= 4 * (LEN_B + 1) + 1; c++) begin
            @(negedge clk);
            if (busy_b) begin
                if (seen_run && gap_len > 0 && gap_len != 1) gaps_bad++;
                if (done_b) done_bad++;
                gap_len = 0;
                run_len++;
                seen_run = 1'b1;
            end else begin
                if (run_len > 0) begin
                    runs.push_back(run_len);
                    if (!done_b) done_bad++;
                end
                run_len = 0;
                gap_len++;
            end
            if (sclk_b && !prev_sclk_b) rx_b = (rx_b << 1) | int'(sdat_b);
            if (latch_b && !prev_latch_b) begin
                got_q.push_back(rx_b);
                rx_b = 0;
            end
            prev_sclk_b = sclk_b;
            prev_latch_b = latch_b;
            if (done_b) begin
                data_b = 8'($urandom);
                exp_q.push_back(frameBits(data_b));
            end
        end
        send_b = 1'b0;
        foreach (runs[i]) if (runs[i] != LEN_B) run_bad++;
        checkOutput("b2b_run_count", runs.size(), 4);
        checkOutput("b2b_run_len", run_bad, 0);
        checkOutput("b2b_gaps", gaps_bad, 0);
        checkOutput("b2b_done", done_bad, 0);
        checkOutput("b2b_rx_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("b2b_rx%0d", i), got_q[i], exp_q[i]);
        repeat (LEN_B + 3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/de1_to_arduino_tx.md
Name: de1_to_arduino_tx

Overview:
- DE1-side transmitter that sends a parallel word (switch/status bits) to the Arduino over three GPIO lines: clock, data and latch.
- Uses a bit-clock frequency divider, so the Arduino can sample with a plain digitalRead on the rising edge of the clock line.
- Complements the Arduino-to-DE1 input path; the Arduino acts as a shift-register-style receiver.
- Sits between the board's switch/key logic and the GPIO header pins.

Parameters:
- DATA_W, 8, number of data bits per frame (1..32).
- DIV, 2500, system clocks per half bit period (>=1); 50 MHz / (2*2500) = 10 kHz gpio_sclk.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- data_in  input  DATA_W  word to transmit; sampled only on an accepted send.
- send  input  1  transmit request; level-sampled each clock.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.
- gpio_sclk  output  1  bit clock to the Arduino.
- gpio_data  output  1  serial data, MSB first.
- gpio_latch  output  1  frame-end strobe to the Arduino.

Behaviour:
- Reset (async, any time, including mid-frame):
  - busy, done, gpio_sclk, gpio_data and gpio_latch all go to 0 immediately.
  - FSM goes to IDLE; divider and bit counter clear.
- FSM states: IDLE, BIT_LO, BIT_HI, LATCH.
- Divider counter: width clog2(DIV) (minimum 1). Counts 0..DIV-1, then wraps to 0 and advances the phase. DIV=1 gives a one-cycle phase.
- IDLE:
  - Outputs are 0.
  - When send=1 at edge T: data_in is captured into the shift register and the FSM enters BIT_LO.
- Timing from an accept at edge T (all values registered, no combinational outputs):
  - Edge T+1: busy=1, gpio_data=MSB.
- BIT_LO:
  - gpio_sclk=0 for DIV cycles; gpio_data stable for the whole phase.
  - Then go to BIT_HI.
- BIT_HI:
  - gpio_sclk=1 for DIV cycles; gpio_data held.
  - At the end of the phase, if more bits remain: shift left, present the next bit and return to BIT_LO.
  - If no bits remain: go to LATCH.
- LATCH:
  - gpio_sclk=0, gpio_data=0, gpio_latch=1 for DIV cycles.
  - Then go to IDLE with done=1 for exactly one cycle and busy=0 in that same cycle.
- Frame length is (2*DATA_W+1)*DIV cycles of busy=1.
- send while busy=1 is ignored (not queued); data_in changes during a frame do not affect it.
- send held high continuously produces back-to-back frames:
  - A new accept is possible in the done cycle.
  - busy deasserts for exactly that one cycle.
- The Arduino samples gpio_data on the rising edge of gpio_sclk and commits the word on the rising edge of gpio_latch.

Optional Feature:
- Macro: DE1_TX_PARITY_EN.
- Defined: one even-parity bit (XOR of all data bits) is sent after the LSB, with the same BIT_LO/BIT_HI timing.
  - Frame length becomes (2*(DATA_W+1)+1)*DIV cycles.
  - Parity is computed from the captured word, not from the live data_in.
- Undefined: no parity bit; frame exactly as described in Behaviour.

Test Plan (DATA_W=8, DIV=4 unless stated):
- Reset, then idle for 20 cycles -> all outputs stay 0; send=0 keeps busy=0.
- data_in=0xA5, one-cycle send at cycle 0:
  - Bits 1,0,1,0,0,1,0,1 are valid at the 8 gpio_sclk rising edges (cycles 5,13,...,61).
  - gpio_latch=1 for cycles 65..68.
  - done=1 at cycle 69 only; busy=1 for cycles 1..68.
- Pulse send again at cycle 10 while busy, with data_in changed to 0xFF -> ignored; the transmitted word is still 0xA5.
- Assert rst at cycle 30 mid-frame -> all outputs 0 asynchronously; after release, a new send of 0x3C transmits a full clean frame.
- send held high, DIV=1 -> back-to-back frames 17 busy cycles long, separated by one done cycle; DIV=1 divider wrap is correct.
- DE1_TX_PARITY_EN defined, data_in=0x07 -> 9th bit=1 and latch delayed by 2*DIV cycles; data_in=0x03 -> 9th bit=0.
